gen_done_signaller: RTL and testbench

//   Synthesizable bank of N_GENERATORS transaction generators; the signalling end
//   of the generator/done-event protocol used by our testbench harness.
//   - One shared start pulse launches every idle generator.
//   - Each generator emits a programmed number of valid/ready transactions,

---
 rtl/gen_done_signaller.sv | 115 +++++++++++
 tb/tb_gen_done_signaller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_done_signaller.sv
// gen_done_signaller: bank of N_GENERATORS valid/ready transaction
// generators sharing one start pulse; each pulses done[i] when finished.
// Ports: clk, rst_n (async low), start, num_txn[i*CW+:CW], txn_valid,
//   txn_ready, txn_data[i*(8+CW)+:8+CW]={i,seq}, busy, done.
// Optional: define GEN_DONE_COUNT_EN to add done_count and all_done.
module gen_done_signaller #(
  parameter int N_GENERATORS = 4,
  parameter int CW           = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [N_GENERATORS*CW-1:0]     num_txn,
  output logic [N_GENERATORS-1:0]        txn_valid,
  input  logic [N_GENERATORS-1:0]        txn_ready,
  output logic [N_GENERATORS*(8+CW)-1:0] txn_data,
  output logic [N_GENERATORS-1:0]        busy,
  output logic [N_GENERATORS-1:0]        done
`ifdef GEN_DONE_COUNT_EN
  ,
  output logic [$clog2(N_GENERATORS+1)-1:0] done_count,
  output logic                              all_done
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  for (genvar g = 0; g < N_GENERATORS; g++) begin : g_ch
    localparam logic [7:0] ID = 8'(g);

    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] seq_q, seq_d;
    logic [CW-1:0] req;

    assign req = num_txn[g*CW +: CW];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        seq_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        seq_q <= seq_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      seq_d = seq_q;
      unique case (st_q)
        IDLE: begin
          if (start) begin
            cnt_d = req;
            seq_d = '0;
            st_d  = (req == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (txn_ready[g]) begin
            // seq tops out at cnt, which never exceeds 2^CW-1
            seq_d = seq_q + CW'(1);
            if (seq_q == cnt_q - CW'(1))
              st_d = DONE;
          end
        end
        DONE:    st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end

    assign txn_valid[g] = (st_q == RUN);
    assign busy[g]      = (st_q != IDLE);
    assign done[g]      = (st_q == DONE);
    // data gated by valid so idle channels present zero
    assign txn_data[g*(8+CW) +: 8+CW] =
      (st_q == RUN) ? {ID, seq_q} : '0;
  end

`ifdef GEN_DONE_COUNT_EN
  localparam int DW = $clog2(N_GENERATORS+1);
  localparam int SW = DW + 1;

  logic [SW-1:0] pop;
  logic [SW-1:0] sum;

  always_comb begin
    pop = '0;
    for (int k = 0; k < N_GENERATORS; k++)
      pop = pop + SW'(done[k]);
    sum = SW'(done_count) + pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done_count <= '0;
    else if (start)
      done_count <= '0;
    else if (sum >= SW'(N_GENERATORS))
      done_count <= DW'(N_GENERATORS);
    else
      done_count <= sum[DW-1:0];
  end

  assign all_done = (done_count == DW'(N_GENERATORS));
`endif

endmodule

// File: tb/tb_gen_done_signaller.sv
// Directed bench for gen_done_signaller: launch table, backpressure,
// start-while-busy, async reset, CW=4 boundary, optional done counter.
module tb_gen_done_signaller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num_txn;
  logic [3:0]  ready, valid, busy, done;
  logic [63:0] data;

  logic        start4;
  logic [3:0]  num4;
  logic [0:0]  ready4, valid4, busy4, done4;
  logic [11:0] data4;

`ifdef GEN_DONE_COUNT_EN
  logic [2:0] done_count;
  logic       all_done;
  logic [0:0] dc4;
  logic       ad4;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gen_done_signaller #(.N_GENERATORS(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_txn(num_txn),
    .txn_valid(valid), .txn_ready(ready), .txn_data(data),
    .busy(busy), .done(done)
`ifdef GEN_DONE_COUNT_EN
    , .done_count(done_count), .all_done(all_done)
`endif
  );

  gen_done_signaller #(.N_GENERATORS(1), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .num_txn(num4),
    .txn_valid(valid4), .txn_ready(ready4), .txn_data(data4),
    .busy(busy4), .done(done4)
`ifdef GEN_DONE_COUNT_EN
    , .done_count(dc4), .all_done(ad4)
`endif
  );

  typedef struct {
    logic        start;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_done;
    logic [3:0]  exp_busy;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nx;
    int   dsum;
    logic got;
    logic [3:0] last;

    tbl[0] = '{1'b1, 4'b1101, 4'b0010, 4'b1111,
               {16'h0300, 16'h0200, 16'h0000, 16'h0000}};
    tbl[1] = '{1'b0, 4'b1001, 4'b0100, 4'b1101,
               {16'h0301, 16'h0000, 16'h0000, 16'h0001}};
    tbl[2] = '{1'b0, 4'b0001, 4'b1000, 4'b1001, 64'h2};
    tbl[3] = '{1'b0, 4'b0000, 4'b0001, 4'b0001, 64'h0};
    tbl[4] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 64'h0};

    num_txn = '0;
    ready   = '0;
    start4  = 1'b0;
    num4    = '0;
    ready4  = 1'b1;

    // reset state
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", data, 0);
    chk("rst_valid4", valid4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // launch table
    num_txn = {8'd2, 8'd1, 8'd0, 8'd3};
    ready   = 4'hF;
    for (int k = 0; k < 5; k++) begin
      start = tbl[k].start;
      step();
      chk($sformatf("l%0d_valid", k), valid, tbl[k].exp_valid);
      chk($sformatf("l%0d_done", k), done, tbl[k].exp_done);
      chk($sformatf("l%0d_busy", k), busy, tbl[k].exp_busy);
      chk($sformatf("l%0d_data", k), data, tbl[k].exp_data);
    end
    start = 1'b0;

    // backpressure on ch0
    num_txn = {8'd0, 8'd0, 8'd0, 8'd2};
    ready   = 4'b1110;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp%0d_valid", j), valid[0], 1);
      chk($sformatf("bp%0d_data", j), data[15:0], 0);
      step();
    end
    chk("bp_hold_valid", valid[0], 1);
    chk("bp_hold_data", data[15:0], 0);
    ready[0] = 1'b1;
    step();
    chk("bp_x1_valid", valid[0], 1);
    chk("bp_x1_data", data[15:0], 16'h0001);
    step();
    chk("bp_done", done[0], 1);
    chk("bp_done_valid", valid[0], 0);
    step();
    chk("bp_idle_done", done, 0);
    chk("bp_idle_busy", busy, 0);

    // start while ch0 busy, ch1 idle
    num_txn = {8'd0, 8'd0, 8'd0, 8'd4};
    ready   = 4'hF;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("sb_seq1", data[15:0], 16'h0001);
    num_txn = {8'd0, 8'd0, 8'd2, 8'd9};
    start   = 1'b1;
    step();
    start = 1'b0;
    dsum  = 0;
    chk("sb_valid", valid, 4'b0011);
    chk("sb_data", data[31:0], {16'h0100, 16'h0002});
    chk("sb_done23", done, 4'b1100);
    step();
    chk("sb_data2", data[31:0], {16'h0101, 16'h0003});
    step();
    chk("sb_done01", done, 4'b0011);
    chk("sb_valid_end", valid, 0);
    for (int j = 0; j < 4; j++) begin
      dsum += int'(done[0]);
      step();
    end
    chk("sb_single_done", dsum, 1);
    chk("sb_busy_end", busy, 0);

    // asynchronous reset in mid-run
    num_txn = {8'd0, 8'd0, 8'd0, 8'd3};
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("ar_seq1", data[15:0], 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_data", data, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    num_txn = {8'd0, 8'd0, 8'd0, 8'd2};
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("ar_re_valid", valid[0], 1);
    chk("ar_re_seq0", data[15:0], 0);
    step();
    chk("ar_re_seq1", data[15:0], 16'h0001);
    step();
    step();

    // CW=4 boundary, count 15
    num4   = 4'hF;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    nx   = 0;
    got  = 1'b0;
    last = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (done4[0]) begin
        got = 1'b1;
      end else begin
        if (valid4[0]) begin
          nx++;
          last = data4[3:0];
        end
        step();
      end
    end
    chk("b_got_done", got, 1);
    chk("b_xfers", nx, 15);
    chk("b_last_seq", last, 4'hE);
    chk("b_valid_at_done", valid4, 0);
    step();

`ifdef GEN_DONE_COUNT_EN
    num_txn = {4{8'd1}};
    ready   = 4'hF;
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("dc_clear", done_count, 0);
    step();
    chk("dc_done_all", done, 4'hF);
    chk("dc_pre", done_count, 0);
    chk("dc_pre_all", all_done, 0);
    step();
    chk("dc_four", done_count, 4);
    chk("dc_all", all_done, 1);
    step();
    chk("dc_hold", done_count, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("dc_restart", done_count, 0);
    chk("dc_restart_all", all_done, 0);
    step();
    step();
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
